// File: rtl/class_mem_pkg.sv
// Shared types and default sizing for the class hypervector bank store.
package class_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_BANKS  = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 13;

endpackage

// File: rtl/class_bank_mem_if.sv
// Write-load and row-read bus of the class bank store.
interface class_bank_mem_if
  import class_mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = ADDR_WIDTH + $clog2(NUM_BANKS) + 1
);
  // A beat transfers on a rising edge where wr_valid && wr_ready; a read is
  // taken where rd_en && rd_ready, and its row appears with rd_valid one cycle later.
  logic                            wr_start;
  logic [ADDR_WIDTH:0]             num_rows;
  logic                            wr_valid;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            wr_ready;
  logic                            write_done;
  logic [CNT_WIDTH-1:0]            beat_count;
  logic                            rd_en;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic                            rd_ready;
  logic                            rd_valid;
  logic                            rd_oob;
  logic [NUM_BANKS*DATA_WIDTH-1:0] class_out;

  modport master (
    output wr_start, num_rows, wr_valid, wr_data, rd_en, rd_addr,
    input  wr_ready, write_done, beat_count, rd_ready, rd_valid, rd_oob, class_out
  );

  modport slave (
    input  wr_start, num_rows, wr_valid, wr_data, rd_en, rd_addr,
    output wr_ready, write_done, beat_count, rd_ready, rd_valid, rd_oob, class_out
  );

endinterface

// File: rtl/class_wr_seq.sv
// Load sequencer: state machine, round-robin bank/row pointers, bank write enables, beat count.
module class_wr_seq
  import class_mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = ADDR_WIDTH + $clog2(NUM_BANKS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_start,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic                  wr_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_ready,
  output logic                  write_done,
  output logic                  rd_ready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [NUM_BANKS-1:0]  bank_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH:0]   num_rows_lat,
  output state_e                state
);

  localparam int BPW = $clog2(NUM_BANKS);
  localparam logic [BPW-1:0]       LAST_BANK = BPW'(NUM_BANKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_WIDTH:0]  ONE_ROW   = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [BPW-1:0]        bank_ptr_q, bank_ptr_d;
  logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d;
  logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;
  logic [ADDR_WIDTH:0]   num_rows_q, num_rows_d;
  logic                  accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bank_ptr_q   <= '0;
      row_ptr_q    <= '0;
      beat_count_q <= '0;
      num_rows_q   <= '0;
    end else begin
      state_q      <= state_d;
      bank_ptr_q   <= bank_ptr_d;
      row_ptr_q    <= row_ptr_d;
      beat_count_q <= beat_count_d;
      num_rows_q   <= num_rows_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bank_ptr_d   = bank_ptr_q;
    row_ptr_d    = row_ptr_q;
    beat_count_d = beat_count_q;
    num_rows_d   = num_rows_q;
    bank_we      = '0;
    // A restart takes priority, so a beat offered alongside wr_start is dropped.
    accept       = (state_q == LOAD) && wr_valid && !wr_start;

    if (wr_start) begin
      num_rows_d   = num_rows;
      bank_ptr_d   = '0;
      row_ptr_d    = '0;
      beat_count_d = '0;
      state_d      = (num_rows == '0) ? DONE : LOAD;
    end else if (accept) begin
      bank_we[bank_ptr_q] = 1'b1;
      if (beat_count_q != CNT_MAX) beat_count_d = beat_count_q + CNT_WIDTH'(1);
      if (bank_ptr_q == LAST_BANK) begin
        bank_ptr_d = '0;
        row_ptr_d  = row_ptr_q + ADDR_WIDTH'(1);
        // Last-beat compare keeps a full-depth load from needing row_ptr to reach num_rows.
        if ({1'b0, row_ptr_q} == num_rows_q - ONE_ROW) state_d = DONE;
      end else begin
        bank_ptr_d = bank_ptr_q + BPW'(1);
      end
    end
  end

  assign wr_ready     = (state_q == LOAD);
  assign write_done   = (state_q == DONE);
  assign rd_ready     = rd_en && !wr_start && (state_q != LOAD);
  assign mem_addr     = (state_q == LOAD) ? row_ptr_q : rd_addr;
  assign beat_count   = beat_count_q;
  assign num_rows_lat = num_rows_q;
  assign state        = state_q;

endmodule

// File: rtl/memory_single.sv
// Single-port RAM bank: synchronous write, combinational read on the shared address.
module memory_single #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/class_bank_mem.sv
// Banked class hypervector store: round-robin element load, one full row read per cycle.
module class_bank_mem
  import class_mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = ADDR_WIDTH + $clog2(NUM_BANKS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  class_bank_mem_if.slave  bus,
  output state_e           state_dbg
);

  localparam int ROW_W = NUM_BANKS * DATA_WIDTH;

  logic [NUM_BANKS-1:0]  bank_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH:0]   num_rows_lat;
  logic [ROW_W-1:0]      row_data;

  logic             rd_valid_q, rd_valid_d;
  logic             rd_oob_q, rd_oob_d;
  logic [ROW_W-1:0] class_out_q, class_out_d;

  class_wr_seq #(
    .NUM_BANKS  (NUM_BANKS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_wr_seq (
    .clk          (clk),
    .reset        (reset),
    .wr_start     (bus.wr_start),
    .num_rows     (bus.num_rows),
    .wr_valid     (bus.wr_valid),
    .rd_en        (bus.rd_en),
    .rd_addr      (bus.rd_addr),
    .wr_ready     (bus.wr_ready),
    .write_done   (bus.write_done),
    .rd_ready     (bus.rd_ready),
    .beat_count   (bus.beat_count),
    .bank_we      (bank_we),
    .mem_addr     (mem_addr),
    .num_rows_lat (num_rows_lat),
    .state        (state_dbg)
  );

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    memory_single #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[k]),
      .addr  (mem_addr),
      .wdata (bus.wr_data),
      .rdata (row_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Banks read combinationally; this register supplies the single cycle of read latency.
  always_comb begin
    rd_valid_d  = bus.rd_ready;
    rd_oob_d    = bus.rd_ready && ({1'b0, bus.rd_addr} >= num_rows_lat);
    class_out_d = bus.rd_ready ? row_data : class_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
      class_out_q <= '0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_oob_q    <= rd_oob_d;
      class_out_q <= class_out_d;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_oob    = rd_oob_q;
  assign bus.class_out = class_out_q;

endmodule

// File: tb/tb_class_bank_mem.sv
// Randomized bench for class_bank_mem against an element-indexed reference model with a read scoreboard.
module tb_class_bank_mem;
  import class_mem_pkg::*;

  localparam int NB    = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int ROWS  = 2**AW;
  localparam int ROW_W = NB * DW;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_DONE = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  class_bank_mem_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  state_e state_dbg;

  class_bank_mem #(
    .NUM_BANKS  (NB),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard entry: {check_oob, oob, row}
  logic [ROW_W+1:0] exp_q[$];

  // reference model: flat element store, element i lives in bank i%NB, row i/NB
  int          m_phase;
  int          m_nrows;
  int          m_cnt;
  logic        m_oob_known;
  logic [DW-1:0] m_mem [NB*ROWS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs applied just after posedge, outputs checked at negedge, model advanced at posedge
  task automatic cycle(input logic ws, input logic [AW:0] nr, input logic wv,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    logic             exp_rd;
    logic [ROW_W+1:0] ent;
    bus.wr_start = ws;
    bus.num_rows = nr;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_en    = re;
    bus.rd_addr  = ra;
    @(negedge clk);
    chk("wr_ready",   bus.wr_ready,   m_phase == P_LOAD);
    chk("write_done", bus.write_done, m_phase == P_DONE);
    chk("beat_count", bus.beat_count, m_cnt);
    exp_rd = re && !ws && (m_phase != P_LOAD);
    chk("rd_ready", bus.rd_ready, exp_rd);
    ent = '0;
    for (int k = 0; k < NB; k++) ent[k*DW +: DW] = m_mem[int'(ra)*NB + k];
    ent[ROW_W]   = (int'(ra) >= m_nrows);
    ent[ROW_W+1] = m_oob_known;
    @(posedge clk);
    if (exp_rd) exp_q.push_back(ent);
    if (ws) begin
      m_nrows     = int'(nr);
      m_cnt       = 0;
      m_phase     = (nr == 0) ? P_DONE : P_LOAD;
      m_oob_known = 1'b1;
    end else if (wv && m_phase == P_LOAD) begin
      m_mem[m_cnt] = wd;
      m_cnt++;
      if (m_cnt == m_nrows * NB) m_phase = P_DONE;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic start(input int nr);
    cycle(1'b1, (AW+1)'(nr), 1'b0, '0, 1'b0, '0);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    cycle(1'b0, '0, 1'b1, d, 1'b0, '0);
  endtask

  task automatic rd(input int a);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, AW'(a));
  endtask

  // monitor: every cycle either pops exactly one expected row or expects no rd_valid
  initial begin : monitor
    logic [ROW_W-1:0] last_row;
    logic [ROW_W+1:0] e;
    last_row = '0;
    forever begin
      @(negedge clk);
      if (!reset) last_row = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_valid", bus.rd_valid, 1'b1);
        chk("class_out", bus.class_out, e[ROW_W-1:0]);
        if (e[ROW_W+1]) chk("rd_oob", bus.rd_oob, e[ROW_W]);
        last_row = e[ROW_W-1:0];
      end else begin
        chk("rd_valid_quiet", bus.rd_valid, 1'b0);
        chk("class_out_hold", bus.class_out, last_row);
      end
    end
  end

  initial begin : stim
    int guard;
    m_phase = P_IDLE; m_nrows = 0; m_cnt = 0; m_oob_known = 1'b0;
    for (int i = 0; i < NB*ROWS; i++) m_mem[i] = '0;
    bus.wr_start = 1'b0; bus.num_rows = '0; bus.wr_valid = 1'b0;
    bus.wr_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;

    // reset state
    @(posedge clk); #1;
    idle(2);
    reset = 1'b1;
    chk("reset_state", state_dbg, IDLE);
    idle(1);

    // load 3 rows of 1..12, read back one at a time
    start(3);
    for (int i = 1; i <= 12; i++) beat(DW'(i));
    idle(1);
    for (int r = 0; r < 3; r++) begin rd(r); idle(1); end

    // same load with random gaps and reads held during LOAD, then streamed readback
    start(3);
    guard = 0;
    while (m_phase != P_DONE && guard < 300) begin
      if ($urandom_range(0, 1) == 1) cycle(1'b0, '0, 1'b1, DW'(m_cnt + 1), 1'b1, AW'($urandom_range(0, 2)));
      else cycle(1'b0, '0, 1'b0, DW'($urandom), 1'b1, AW'($urandom_range(0, 2)));
      guard++;
    end
    if (m_phase != P_DONE) begin
      n_vec++; n_err++;
      $display("FAIL gap_load_timeout: beats %0d required %0d", m_cnt, 12);
    end
    rd(0); rd(1); rd(2); idle(1);

    // restart mid-load; beat offered with the restart is dropped
    start(3);
    for (int i = 0; i < 5; i++) beat(DW'($urandom));
    cycle(1'b1, (AW+1)'(1), 1'b1, 8'hEE, 1'b0, '0);
    for (int i = 0; i < 4; i++) beat(8'hA0 + DW'(i));
    idle(1);
    rd(0); rd(1); idle(1);

    // full-depth load with random data
    start(ROWS);
    for (int i = 0; i < NB*ROWS; i++) beat(DW'($urandom));
    idle(1);
    rd(ROWS-1); rd(0); rd($urandom_range(1, ROWS-2)); idle(1);

    // zero-row load goes straight to DONE
    start(0);
    idle(1);
    rd(0); idle(1);

    // out-of-range read
    start(3);
    for (int i = 0; i < 12; i++) beat(DW'($urandom));
    idle(1);
    rd(5); rd(2); idle(1);

    // wr_start and rd_en together in DONE: read dropped, load restarts
    cycle(1'b1, (AW+1)'(3), 1'b0, '0, 1'b1, AW'(2));
    for (int i = 0; i < 12; i++) beat(DW'($urandom));
    idle(1);
    for (int i = 0; i < 6; i++) rd($urandom_range(0, ROWS-1));
    idle(1);

    // asynchronous reset in the middle of a load
    start(3);
    for (int i = 0; i < 8; i++) beat(DW'($urandom));
    #2;
    reset = 1'b0;
    m_phase = P_IDLE; m_cnt = 0; m_oob_known = 1'b0;
    #1;
    chk("async_wr_ready",   bus.wr_ready,   1'b0);
    chk("async_write_done", bus.write_done, 1'b0);
    chk("async_rd_valid",   bus.rd_valid,   1'b0);
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    chk("post_reset_state", state_dbg, IDLE);
    cycle(1'b0, '0, 1'b1, 8'h55, 1'b0, '0);
    rd(0); rd(1); idle(3);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
